// File: rtl/data_memory_ctrl.sv
// Data memory with byte/half/word access, wait-state handshake, post-reset zero-fill and error reporting.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned half/word requests complete with err instead of being force-aligned.
module data_memory_ctrl #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 1,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              done,
   output logic              err
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

   state_t             state, state_n;
   logic [IDX_W-1:0]   clr_idx, clr_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               cap_c;
   logic               ready_n, done_n, err_n;
   logic [31:0]        rdata_n;

   logic [ADDR_W-1:0]  addr_q;
   logic [1:0]         size_q;
   logic               uns_q, wr_q, rd_q;
   logic [31:0]        wdata_q;

   logic [31:0]        mem [DEPTH];
   logic               mem_we_c;
   logic [IDX_W-1:0]   mem_idx_c;
   logic [3:0]         mem_be_c;
   logic [31:0]        mem_wd_c;

   logic [IDX_W-1:0]   idx_c;
   logic [1:0]         lane_c;
   logic               illegal_c;
   logic               misalign_c;
   logic [31:0]        word_c, shifted_c, ld_c;
   logic [3:0]         st_be_c;
   logic [31:0]        st_wd_c;

   // Decode of the captured request
   always_comb begin
      idx_c = addr_q[IDX_W+1:2];
      case (size_q)
         2'b00:   lane_c = addr_q[1:0];
         2'b01:   lane_c = {addr_q[1], 1'b0};
         default: lane_c = 2'b00;
      endcase
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_c = ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
      misalign_c = 1'b0;
`endif
      illegal_c = (rd_q == wr_q) || (size_q == 2'b11) ||
                  (|(addr_q >> (IDX_W + 2))) || misalign_c;
   end

   // Load extraction and store lane steering
   always_comb begin
      word_c    = mem[idx_c];
      shifted_c = word_c >> {lane_c, 3'b000};
      case (size_q)
         2'b00: begin
            ld_c     = uns_q ? {24'd0, shifted_c[7:0]} : {{24{shifted_c[7]}}, shifted_c[7:0]};
            st_be_c  = 4'b0001 << lane_c;
            st_wd_c  = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            ld_c     = uns_q ? {16'd0, shifted_c[15:0]} : {{16{shifted_c[15]}}, shifted_c[15:0]};
            st_be_c  = lane_c[1] ? 4'b1100 : 4'b0011;
            st_wd_c  = {2{wdata_q[15:0]}};
         end
         default: begin
            ld_c     = word_c;
            st_be_c  = 4'b1111;
            st_wd_c  = wdata_q;
         end
      endcase
   end

   // Next-state and output logic
   always_comb begin
      state_n   = state;
      clr_n     = clr_idx;
      cnt_n     = cnt;
      cap_c     = 1'b0;
      ready_n   = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b0;
      rdata_n   = rdata;
      mem_we_c  = 1'b0;
      mem_idx_c = idx_c;
      mem_be_c  = st_be_c;
      mem_wd_c  = st_wd_c;
      case (state)
         CLEAR: begin
            mem_we_c  = 1'b1;
            mem_idx_c = clr_idx;
            mem_be_c  = 4'b1111;
            mem_wd_c  = 32'd0;
            clr_n     = IDX_W'(clr_idx + 1'b1);
            if (clr_idx == IDX_W'(DEPTH - 1)) begin
               state_n = IDLE;
               ready_n = 1'b1;
            end
         end
         IDLE: begin
            ready_n = 1'b1;
            if (req && ready) begin
               cap_c   = 1'b1;
               cnt_n   = CNT_W'(LATENCY);
               state_n = BUSY;
               ready_n = 1'b0;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_n  = IDLE;
               ready_n  = 1'b1;
               done_n   = 1'b1;
               err_n    = illegal_c;
               mem_we_c = wr_q && !illegal_c;
               if (rd_q)
                  rdata_n = illegal_c ? 32'd0 : ld_c;
            end else begin
               cnt_n = CNT_W'(cnt - 1'b1);
            end
         end
         default: state_n = CLEAR;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
         cnt     <= '0;
         ready   <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'd0;
         addr_q  <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         wdata_q <= 32'd0;
      end else begin
         state   <= state_n;
         clr_idx <= clr_n;
         cnt     <= cnt_n;
         ready   <= ready_n;
         done    <= done_n;
         err     <= err_n;
         rdata   <= rdata_n;
         if (cap_c) begin
            addr_q  <= addr;
            size_q  <= size;
            uns_q   <= unsigned_ld;
            wr_q    <= MemWrite;
            rd_q    <= MemRead;
            wdata_q <= wdata;
         end
      end
   end

   // Storage; reset aborts any pending write
   always_ff @(posedge clk) begin
      if (!rst && mem_we_c) begin
         for (int b = 0; b < 4; b++)
            if (mem_be_c[b])
               mem[mem_idx_c][8*b +: 8] <= mem_wd_c[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: byte-array reference model, randomized and directed requests.
module tb_data_memory_ctrl;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        MemWrite = 1'b0, MemRead = 1'b0, unsigned_ld = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [1:0]  size = 2'b00;
   logic [31:0] rdata;
   logic        ready, done, err;

   data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .MemWrite(MemWrite), .MemRead(MemRead),
      .addr(addr), .size(size), .unsigned_ld(unsigned_ld), .wdata(wdata),
      .rdata(rdata), .ready(ready), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int unsigned t;
      string       name;
   } exp_t;
   exp_t q[$];

   // Reference model: memory as a flat little-endian byte array
   logic [7:0]  mbytes [DEPTH*4];
   logic [31:0] m_rdata;

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH*4); i++) mbytes[i] = 8'h00;
      m_rdata = 32'd0;
   endtask

   task automatic model(input logic wr, input logic rd, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] exp_rd, output logic exp_err);
      int unsigned n, base, ai;
      logic [31:0] val;
      logic bad;
      bad = (wr == rd) || (sz == 2'b11) || ((a >> 2) >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
      bad = bad || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
      if (bad) begin
         if (rd) m_rdata = 32'd0;
      end else begin
         n    = 1 << sz;
         ai   = a;
         base = (ai / n) * n;
         if (wr) begin
            for (int i = 0; i < int'(n); i++) mbytes[base + i] = wd[8*i +: 8];
         end else begin
            val = 32'd0;
            for (int i = 0; i < int'(n); i++) val = val | (32'(mbytes[base + i]) << (8*i));
            if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 1);
            m_rdata = val;
         end
      end
      exp_rd  = m_rdata;
      exp_err = bad;
   endtask

   // Issue one request when ready (called at a negedge); expected response goes to the scoreboard
   task automatic issue(input logic wr, input logic rd, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input string name);
      int unsigned w = 0;
      exp_t e;
      while (!ready) begin
         @(negedge clk);
         w++;
         if (w > 200) begin
            tests++; fails++;
            $display("FAIL %s: ready_timeout ready=%0d required=1", name, ready);
            return;
         end
      end
      MemWrite = wr; MemRead = rd; addr = a; size = sz; unsigned_ld = uns; wdata = wd; req = 1'b1;
      @(posedge clk);
      #1;
      e.t = cyc;
      e.name = name;
      model(wr, rd, a, sz, uns, wd, e.rd, e.er);
      q.push_back(e);
      @(negedge clk);
      req = 1'b0;
      MemWrite = $urandom_range(0, 1); MemRead = $urandom_range(0, 1); addr = $urandom();
   endtask

   task automatic reset_dut();
      int unsigned n = 0;
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      repeat (2) @(negedge clk);
      tests++;
      if (ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_values: ready=%0d done=%0d err=%0d rdata=%h required 0 0 0 00000000",
                  ready, done, err, rdata);
      end
      rst = 1'b0;
      model_reset();
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n != DEPTH) begin
         fails++;
         $display("FAIL clear_cycles: ready low for %0d cycles, required %0d", n, DEPTH);
      end
   endtask

   // Monitor: pops the scoreboard whenever done is presented
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL spurious_done: done=1 with no request outstanding, required done=0");
            end else begin
               e = q.pop_front();
               if (rdata !== e.rd || err !== e.er || (cyc - e.t) != LAT + 1) begin
                  fails++;
                  $display("FAIL %s: rdata=%h err=%0d latency=%0d, required rdata=%h err=%0d latency=%0d",
                           e.name, rdata, err, cyc - e.t, e.rd, e.er, LAT + 1);
               end
            end
         end else if (err) begin
            tests++; fails++;
            $display("FAIL err_without_done: err=1 done=0, required err=0");
         end else if (q.size() > 0 && ready) begin
            tests++; fails++;
            $display("FAIL ready_in_busy: ready=1 while request outstanding, required 0");
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        wr, rd, uns;
      logic [31:0] a;
      logic [1:0]  sz;
      int unsigned r, w;

      reset_dut();
      issue(0, 1, 32'h3C, 2'b10, 0, 32'h0, "ld_cleared_3c");
      issue(1, 0, 32'h08, 2'b10, 0, 32'h11223344, "st_word_08");
      issue(1, 0, 32'h0A, 2'b00, 0, 32'h000000AB, "st_byte_0a");
      issue(0, 1, 32'h08, 2'b10, 0, 32'h0, "ld_word_08");
      issue(0, 1, 32'h0A, 2'b00, 0, 32'h0, "ld_sbyte_0a");
      issue(0, 1, 32'h0A, 2'b00, 1, 32'h0, "ld_ubyte_0a");
      issue(1, 0, 32'h400, 2'b10, 0, 32'h55555555, "st_out_of_range");
      issue(0, 1, 32'h00, 2'b10, 0, 32'h0, "ld_after_oor");
      issue(1, 1, 32'h04, 2'b10, 0, 32'h12345678, "rd_and_wr");
      issue(0, 0, 32'h04, 2'b10, 0, 32'h12345678, "no_cmd");
      issue(0, 1, 32'h04, 2'b11, 0, 32'h0, "size_11");
      issue(1, 0, 32'h04, 2'b10, 0, 32'hCAFEBABE, "st_word_04");
      issue(0, 1, 32'h06, 2'b10, 0, 32'h0, "ld_word_misaligned_06");
      issue(0, 1, 32'h05, 2'b01, 0, 32'h0, "ld_half_misaligned_05");
      issue(0, 1, 32'h3F, 2'b00, 1, 32'h0, "ld_last_byte");

      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 9);
         wr = (r == 0) || (r >= 2 && r <= 5);
         rd = (r == 0) || (r >= 6);
         a  = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH*4 - 1));
         sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         uns = $urandom_range(0, 1);
         issue(wr, rd, a, sz, uns, $urandom(), "random");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset during BUSY: store must be dropped and no done produced
      issue(1, 0, 32'h10, 2'b10, 0, 32'hDEADBEEF, "st_aborted");
      reset_dut();
      issue(0, 1, 32'h10, 2'b10, 0, 32'h0, "ld_after_abort");

      w = 0;
      while (q.size() > 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (q.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
